// File: rtl/code_dec_pkg.sv
// code_dec_pkg: state encoding and code-to-digit tables for the code decoder
package code_dec_pkg;
  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  localparam logic [3:0] BAD_DIGIT = 4'hF;
  // nibble i of DIGIT_TAB is the digit for code i; invalid codes map to BAD_DIGIT
  localparam logic [63:0] DIGIT_TAB = 64'h9FFF_5678_1234_FFF0;
  localparam logic [15:0] CODE_OK = 16'h8FF1;
endpackage

// File: rtl/code_dec_nib.sv
// code_dec_nib: combinational single-nibble code to BCD digit decoder
module code_dec_nib
  import code_dec_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [3:0] digit_o,
  output logic       bad_o
);
  assign digit_o = DIGIT_TAB[{code_i, 2'b00} +: 4];
  assign bad_o = ~CODE_OK[code_i];
endmodule

// File: rtl/code_dec.sv
// code_dec: collects NDIG code nibbles into BCD and binary results with a valid/ready handshake
module code_dec
  import code_dec_pkg::*;
#(
  parameter int NDIG = 4,
  parameter int BW = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] out_bcd,
  output logic [BW-1:0]     out_bin,
  output logic              out_err
);
  localparam int CW = NDIG > 1 ? $clog2(NDIG) : 1;
  logic [0:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [4*NDIG-1:0] bcd_q, bcd_d;
  logic [BW-1:0]     bin_q, bin_d;
  logic              err_q, err_d;
  logic [3:0]        digit;
  logic              bad, take, done, last;
  code_dec_nib u_nib (
    .code_i (in_code),
    .digit_o(digit),
    .bad_o  (bad)
  );
  // invalid codes still shift BAD_DIGIT into the BCD image but add nothing to the binary value
  always_comb begin
    take = in_valid && state_q == COLLECT;
    done = out_ready && state_q == HOLD;
    last = cnt_q == CW'(NDIG - 1);
    state_d = take && last ? HOLD : done ? COLLECT : state_q;
    cnt_d = take ? (last ? '0 : cnt_q + CW'(1)) : cnt_q;
    bcd_d = done ? '0 : take ? (bcd_q << 4) | (4*NDIG)'(digit) : bcd_q;
    bin_d = done ? '0 : take ? bin_q * BW'(10) + (bad ? '0 : BW'(digit)) : bin_q;
    err_d = done ? 1'b0 : take ? err_q | bad : err_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      cnt_q <= '0;
      bcd_q <= '0;
      bin_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bcd_q <= bcd_d;
      bin_q <= bin_d;
      err_q <= err_d;
    end
  end
  assign in_ready = state_q == COLLECT;
  assign out_valid = state_q == HOLD;
  assign out_bcd = bcd_q;
  assign out_bin = bin_q;
  assign out_err = err_q;
endmodule

// File: doc/code_dec.md
CODE_DEC -- requirements
Module: code_dec

Interface
REQ-001 Parameter NDIG, default 4: number of code nibbles per frame (>=1).
REQ-002 Parameter BW, default 14: binary result width; 2**BW SHALL exceed 10**NDIG-1.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  in_code holds a code nibble.
REQ-006 in_ready  out  1  block can accept a nibble; transfer occurs when in_valid&in_ready at the clock edge.
REQ-007 in_code  in  4  code nibble, most-significant digit first.
REQ-008 out_valid  out  1  frame result available.
REQ-009 out_ready  in  1  consumer accepts result; transfer occurs when out_valid&out_ready at the clock edge.
REQ-010 out_bcd  out  4*NDIG  decoded BCD digits, first-received digit in MS nibble.
REQ-011 out_bin  out  BW  binary value of the decoded digits.
REQ-012 out_err  out  1  frame contained at least one invalid code.

Function
REQ-013 Nibble decode map, code->digit: 0->0, 4->4, 5->3, 6->2, 7->1, 8->8, 9->7, 10->6, 11->5, 15->9.
REQ-014 Codes 1, 2, 3, 12, 13, 14 are invalid; each SHALL decode to BCD digit 4'hF, contribute 0 to out_bin, and set the frame error flag.
REQ-015 Two FSM states: COLLECT (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-016 In COLLECT, each accepted nibble shifts its decoded digit into the BCD register from the LS end and sets bin = bin*10 + digit, truncated to BW bits.
REQ-017 A digit counter counts accepted nibbles 0..NDIG-1; acceptance of the NDIG-th nibble clears the counter and moves the FSM to HOLD.
REQ-018 out_valid rises in the first cycle after the NDIG-th nibble is accepted.
REQ-019 In HOLD, out_bcd, out_bin and out_err are stable until the result is accepted, and in_valid is ignored.
REQ-020 On the out_valid&out_ready edge, the FSM moves to COLLECT, and bcd, bin and the error flag clear to 0, so in_ready=1 in the next cycle.
REQ-021 Throughput: one frame per NDIG+1 cycles when in_valid and out_ready are held high.
REQ-022 In COLLECT with in_valid=0, no register changes.
REQ-023 Outputs are registered; there is no combinational path from in_code to out_*.
REQ-024 out_bcd, out_bin and out_err in COLLECT reflect partial accumulation; they are valid only while out_valid=1.

Reset
REQ-025 While rst_n=0: state=COLLECT, counter=0, bcd=0, bin=0, err=0, out_valid=0, in_ready=1.
REQ-026 Assertion of rst_n mid-frame or in HOLD discards the partial or held frame without producing a result.
REQ-027 The first transfer after reset release is accepted on the first rising edge with rst_n=1.

Structure
REQ-028 Package code_dec_pkg holds the state encoding (COLLECT, HOLD), the invalid-digit constant 4'hF, and the code->digit table constants.
REQ-029 Sub-module code_dec_nib: combinational, in_code[3:0] -> digit[3:0] plus invalid flag; instantiated once by code_dec.

Verification
REQ-030 Reset, then codes 7,6,5,4 with NDIG=4 -> out_valid one cycle after the 4th nibble; out_bcd=16'h1234, out_bin=1234, out_err=0.
REQ-031 Codes 15,15,15,15 -> out_bcd=16'h9999, out_bin=9999, out_err=0.
REQ-032 Codes 0,2,8,11 -> out_bcd=16'h0F85, out_bin=85, out_err=1.
REQ-033 Hold out_ready=0 for 5 cycles while driving in_valid=1 -> in_ready=0 and outputs stable; a single out_ready pulse -> in_ready=1 on the next cycle, and the next frame 0,0,0,8 yields out_bin=8.
REQ-034 Drop rst_n after 2 nibbles, then send a full frame 10,9,8,4 -> out_bcd=16'h6784; no result is produced for the aborted frame.
REQ-035 Drive in_valid continuously with out_ready=1 -> one frame every 5 cycles; checker compares every frame against the REQ-013 table model.
